serial_sub: RTL and testbench

- Bit-serial, multi-cycle unsigned subtractor: out = in1 - in2, with a final borrow output.
- Inverse-direction companion to the team's combinational 8-bit adder.
- Used where adder-checking or datapath-reversal logic needs a difference at minimal area.
- Start/done handshake; LSB-first, one result bit per clock; operands latched at start.

---
 rtl/serial_sub_if.sv | 39 +++
 rtl/serial_sub.sv | 156 +++++++++++++++
 tb/tb_serial_sub.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/done handshake and operand/result bundle for serial_sub.
// Signals: start, in1, in2 (requester -> subtractor); busy, done, out, borrow
// (subtractor -> requester); zero, neg, ovf only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output start, in1, in2,
    input  busy, done, out, borrow, zero, neg, ovf
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, out, borrow, zero, neg, ovf
  );
`else
  modport master (
    output start, in1, in2,
    input  busy, done, out, borrow
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, out, borrow
  );
`endif
endinterface

// File: rtl/serial_sub.sv
// Purpose: bit-serial unsigned subtractor, out = in1 - in2 (mod 2^WIDTH), LSB first.
// Latency: start sampled at edge N -> done pulse in the cycle after edge N+WIDTH.
// Backpressure: none; start is only accepted in IDLE/DONE, ignored while busy.
// Ports: clk, rst_n (sync, active-low); bus (serial_sub_if.slave): start/in1/in2
// in, busy/done/out/borrow out. Optional macro SERIAL_SUB_FLAGS_EN adds the
// zero/neg/ovf result flags, registered together with out.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] out_q;
  logic             borrow_q;

  logic             accept;
  logic             last_bit;
  logic             diff_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] acc_nxt;

`ifdef SERIAL_SUB_FLAGS_EN
  logic             a_msb;
  logic             b_msb;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
`endif

  // A new operation may begin from IDLE or directly out of DONE (back-to-back).
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);

  // One full-subtractor slice per clock on the current LSBs.
  assign diff_bit = a[0] ^ b[0] ^ br;
  assign br_nxt   = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
  // New bit enters at the MSB so after WIDTH shifts bit 0 lands at acc[0].
  assign acc_nxt  = (acc >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? SHIFT : IDLE;
      SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      SHIFT:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, accumulator, borrow and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      acc <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      a   <= bus.in1;
      b   <= bus.in2;
      acc <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      a   <= a >> 1;
      b   <= b >> 1;
      acc <= acc_nxt;
      br  <= br_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Result registers: loaded only on the edge that enters DONE, so they hold
  // through IDLE and through the SHIFT phase of the following operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      borrow_q <= 1'b0;
    end else if (last_bit) begin
      out_q    <= acc_nxt;
      borrow_q <= br_nxt;
    end
  end

  assign bus.out    = out_q;
  assign bus.borrow = borrow_q;

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand sign bits are captured at start because a/b are shifted away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= bus.in1[WIDTH-1];
        b_msb <= bus.in2[WIDTH-1];
      end
      if (last_bit) begin
        zero_q <= (acc_nxt == '0);
        // The final difference bit is the result MSB.
        neg_q  <= diff_bit;
        ovf_q  <= (a_msb != b_msb) && (diff_bit != a_msb);
      end
    end
  end

  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub (WIDTH=8): directed vectors with hand-computed results.
// Covers reset state, latency/busy length, wrap-around, back-to-back starts,
// ignored start while busy, mid-operation reset and (if enabled) result flags.
module tb_serial_sub;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_sub_if #(.WIDTH(8)) bus ();

  serial_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done; cyc counts edges after the start edge. Bounded.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    while (bus.done !== 1'b1 && cyc < 30) begin
      if (bus.busy === 1'b1) nbusy++;
      step();
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] eo, input logic eb);
    int cyc;
    int nbusy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = x;
    bus.in2   = y;
    step();
    bus.start = 1'b0;
    wait_done(cyc, nbusy);
    chk({tag, "_lat"}, cyc, 8);
    chk({tag, "_busy"}, nbusy, 8);
    chk({tag, "_out"}, bus.out, eo);
    chk({tag, "_brw"}, bus.borrow, eb);
    step();
    chk({tag, "_pulse"}, bus.done, 1'b0);
  endtask

  task automatic count_done(input int ncyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  logic [7:0] b2b_a [3];
  logic [7:0] b2b_b [3];
  logic [7:0] b2b_o [3];
  logic       b2b_r [3];

  initial begin
    int t;
    int nb;
    int pulses;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_out", bus.out, 8'h00);
    chk("rst_brw", bus.borrow, 1'b0);
    rst_n = 1'b1;
    step();

    do_op("op50m20", 8'h50, 8'h20, 8'h30, 1'b0);
    do_op("op20m50", 8'h20, 8'h50, 8'hD0, 1'b1);
    do_op("op00m01", 8'h00, 8'h01, 8'hFF, 1'b1);
    do_op("opFFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0);

    // Back-to-back with start held high.
    b2b_a = '{8'h10, 8'h80, 8'h01};
    b2b_b = '{8'h01, 8'h7F, 8'h02};
    b2b_o = '{8'h0F, 8'h01, 8'hFF};
    b2b_r = '{1'b0, 1'b0, 1'b1};
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = b2b_a[0];
    bus.in2   = b2b_b[0];
    step();
    t = 0;
    for (int i = 0; i < 3; i++) begin
      while (bus.done !== 1'b1 && t < 9 * i + 20) begin
        step();
        t++;
      end
      chk($sformatf("b2b%0d_t", i), t, 9 * i + 8);
      chk($sformatf("b2b%0d_out", i), bus.out, b2b_o[i]);
      chk($sformatf("b2b%0d_brw", i), bus.borrow, b2b_r[i]);
      if (i < 2) begin
        bus.in1 = b2b_a[i+1];
        bus.in2 = b2b_b[i+1];
        step();
        t++;
        if (i == 1) bus.start = 1'b0;
      end
    end
    step();

    // Start and operand changes while busy are ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 8'h33;
    bus.in2   = 8'h11;
    step();
    bus.start = 1'b0;
    repeat (2) step();
    bus.in1   = 8'h00;
    bus.in2   = 8'hFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(t, nb);
    chk("ign_lat", t, 5);
    chk("ign_out", bus.out, 8'h22);
    chk("ign_brw", bus.borrow, 1'b0);
    count_done(14, pulses);
    chk("ign_pulses", pulses, 0);

    // Reset in the middle of SHIFT discards the partial result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = 8'h90;
    bus.in2   = 8'h10;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk("mid_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_done", bus.done, 1'b0);
    chk("mid_out", bus.out, 8'h00);
    chk("mid_brw", bus.borrow, 1'b0);
    count_done(14, pulses);
    chk("mid_pulses", pulses, 0);
    do_op("op90m10", 8'h90, 8'h10, 8'h80, 1'b0);

`ifdef SERIAL_SUB_FLAGS_EN
    do_op("fl80m01", 8'h80, 8'h01, 8'h7F, 1'b0);
    chk("fl80m01_ovf", bus.ovf, 1'b1);
    chk("fl80m01_neg", bus.neg, 1'b0);
    chk("fl80m01_zero", bus.zero, 1'b0);
    do_op("fl05m05", 8'h05, 8'h05, 8'h00, 1'b0);
    chk("fl05m05_zero", bus.zero, 1'b1);
    chk("fl05m05_ovf", bus.ovf, 1'b0);
    do_op("fl01m02", 8'h01, 8'h02, 8'hFF, 1'b1);
    chk("fl01m02_neg", bus.neg, 1'b1);
    chk("fl01m02_ovf", bus.ovf, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
